// File: rtl/phv_action_sync.sv
// phv_action_sync: pairs each PHV with its action bundle ahead of the stage ALU crossbar.
// The design buffers PHVs and action bundles in two independent FIFOs. It pops one of each
// together and presents the pair on a registered valid/ready output.
//
// Optional feature: define PHV_ACT_SYNC_TIMEOUT_EN to add a partner-wait timeout.
// An expired lone PHV passes through with an all-zero (no-op) action bundle.
// An expired lone action bundle is discarded and counted in drop_cnt.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   phv_in / phv_in_valid    PHV stream from the previous stage
//   phv_ready_out            PHV FIFO can accept this cycle
//   action_in / _valid       action bundle stream, no back-pressure
//   phv_out / action_out     aligned pair to the crossbar
//   out_valid / ready_in     output handshake
//   act_overflow             sticky: an action bundle was dropped on a full FIFO
//   drop_cnt                 saturating count of dropped action bundles
//   phv_level                PHV FIFO occupancy
module phv_action_sync #(
  parameter int unsigned STAGE_ID   = 0,
  parameter int unsigned PHV_LEN    = 1024,
  parameter int unsigned ACT_LEN    = 25,
  parameter int unsigned ACT_NUM    = 25,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_in_valid,
  output logic                       phv_ready_out,
  input  logic [ACT_LEN*ACT_NUM-1:0] action_in,
  input  logic                       action_in_valid,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic [ACT_LEN*ACT_NUM-1:0] action_out,
  output logic                       out_valid,
  input  logic                       ready_in,
  output logic                       act_overflow,
  output logic [15:0]                drop_cnt,
  output logic [DEPTH_LOG2:0]        phv_level
);

  localparam int unsigned ActW  = ACT_LEN * ACT_NUM;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  logic [PHV_LEN-1:0] phv_mem [Depth];
  logic [ActW-1:0]    act_mem [Depth];

  logic [PtrW-1:0] phv_wr_q, phv_wr_d, phv_rd_q, phv_rd_d;
  logic [PtrW-1:0] act_wr_q, act_wr_d, act_rd_q, act_rd_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [ActW-1:0]    act_out_q, act_out_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic phv_empty, phv_full, act_empty, act_full;
  logic can_load, pair_pop, phv_pop, act_pop, phv_push, act_push;
  logic zero_act, discard, act_drop;

  // Extra pointer bit distinguishes full from empty.
  assign phv_empty = (phv_wr_q == phv_rd_q);
  assign act_empty = (act_wr_q == act_rd_q);
  assign phv_full  = ((phv_wr_q - phv_rd_q) == PtrW'(Depth));
  assign act_full  = ((act_wr_q - act_rd_q) == PtrW'(Depth));

  // Held low during reset; not raised by a same-cycle pop.
  assign phv_ready_out = !phv_full && !rst;
  assign phv_push      = phv_in_valid && phv_ready_out;

`ifdef PHV_ACT_SYNC_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);
  // A lone head expires on the cycle after it has waited TIMEOUT cycles.
  localparam logic [CntW-1:0] Expire = CntW'(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            lone, expired;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  logic [31:0] unused_stage_id;
  assign unused_stage_id = 32'(STAGE_ID);

  always_comb begin
    can_load = !out_valid_q || ready_in;
    pair_pop = !phv_empty && !act_empty && can_load;
    phv_pop  = pair_pop;
    act_pop  = pair_pop;
    zero_act = 1'b0;
    discard  = 1'b0;
`ifdef PHV_ACT_SYNC_TIMEOUT_EN
    lone       = (phv_empty != act_empty);
    expired    = lone && (wait_cnt_q == Expire);
    wait_cnt_d = wait_cnt_q;
    // An expired PHV still has to wait for the output register to free up.
    if (expired && !phv_empty && can_load) begin
      phv_pop  = 1'b1;
      zero_act = 1'b1;
    end
    if (expired && !act_empty) begin
      act_pop = 1'b1;
      discard = 1'b1;
    end
    if (!lone || phv_pop || act_pop) begin
      wait_cnt_d = '0;
    end else if (!expired) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
`endif

    // A full action FIFO still accepts when its head leaves this cycle.
    act_push = action_in_valid && (!act_full || act_pop);
    act_drop = action_in_valid && act_full && !act_pop;

    phv_wr_d = phv_push ? phv_wr_q + 1'b1 : phv_wr_q;
    phv_rd_d = phv_pop  ? phv_rd_q + 1'b1 : phv_rd_q;
    act_wr_d = act_push ? act_wr_q + 1'b1 : act_wr_q;
    act_rd_d = act_pop  ? act_rd_q + 1'b1 : act_rd_q;

    phv_out_d   = phv_out_q;
    act_out_d   = act_out_q;
    out_valid_d = out_valid_q;
    if (phv_pop) begin
      phv_out_d   = phv_mem[phv_rd_q[DEPTH_LOG2-1:0]];
      act_out_d   = zero_act ? '0 : act_mem[act_rd_q[DEPTH_LOG2-1:0]];
      out_valid_d = 1'b1;
    end else if (ready_in) begin
      out_valid_d = 1'b0;
    end

    overflow_d = overflow_q || act_drop;
    drop_cnt_d = drop_cnt_q;
    if ((act_drop || discard) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Storage arrays carry no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (phv_push) phv_mem[phv_wr_q[DEPTH_LOG2-1:0]] <= phv_in;
    if (act_push) act_mem[act_wr_q[DEPTH_LOG2-1:0]] <= action_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_wr_q    <= '0;
      phv_rd_q    <= '0;
      act_wr_q    <= '0;
      act_rd_q    <= '0;
      phv_out_q   <= '0;
      act_out_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      phv_wr_q    <= phv_wr_d;
      phv_rd_q    <= phv_rd_d;
      act_wr_q    <= act_wr_d;
      act_rd_q    <= act_rd_d;
      phv_out_q   <= phv_out_d;
      act_out_q   <= act_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef PHV_ACT_SYNC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign phv_out      = phv_out_q;
  assign action_out   = act_out_q;
  assign out_valid    = out_valid_q;
  assign act_overflow = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign phv_level    = phv_wr_q - phv_rd_q;

endmodule

// File: tb/tb_phv_action_sync.sv
// Self-checking bench for phv_action_sync (default build, timeout feature off).
// The reference model keeps both FIFOs as queues and the output stage as plain variables.
module tb_phv_action_sync;

  localparam int PL = 1024;
  localparam int AW = 625;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PL-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_ready_out;
  logic [AW-1:0] action_in;
  logic          action_in_valid;
  logic [PL-1:0] phv_out;
  logic [AW-1:0] action_out;
  logic          out_valid;
  logic          ready_in;
  logic          act_overflow;
  logic [15:0]   drop_cnt;
  logic [3:0]    phv_level;

  phv_action_sync dut (
    .clk             (clk),
    .rst             (rst),
    .phv_in          (phv_in),
    .phv_in_valid    (phv_in_valid),
    .phv_ready_out   (phv_ready_out),
    .action_in       (action_in),
    .action_in_valid (action_in_valid),
    .phv_out         (phv_out),
    .action_out      (action_out),
    .out_valid       (out_valid),
    .ready_in        (ready_in),
    .act_overflow    (act_overflow),
    .drop_cnt        (drop_cnt),
    .phv_level       (phv_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [PL-1:0] phv_q[$];
  logic [AW-1:0] act_q[$];
  logic          m_valid;
  logic [PL-1:0] m_phv;
  logic [AW-1:0] m_act;
  logic          m_ovf;
  int            m_drop;

  function automatic logic [PL-1:0] rnd_phv();
    logic [PL-1:0] v;
    for (int i = 0; i < PL / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_act();
    logic [639:0] v;
    for (int i = 0; i < 20; i++) v[i*32 +: 32] = $urandom();
    return v[AW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic check_all();
    logic exp_rdy;
    exp_rdy = !rst && (phv_q.size() < DEPTH);
    chk("out_valid", PL'(out_valid), PL'(m_valid));
    chk("phv_out", phv_out, m_phv);
    chk("action_out", PL'(action_out), PL'(m_act));
    chk("act_overflow", PL'(act_overflow), PL'(m_ovf));
    chk("drop_cnt", PL'(drop_cnt), PL'(m_drop));
    chk("phv_level", PL'(phv_level), PL'(phv_q.size()));
    chk("phv_ready_out", PL'(phv_ready_out), PL'(exp_rdy));
  endtask

  task automatic model_clear();
    phv_q.delete();
    act_q.delete();
    m_valid = 1'b0;
    m_phv   = '0;
    m_act   = '0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  // One clock: drive, advance the model by the same rules, check after the edge.
  task automatic cycle(input logic pv, input logic av, input logic rdy);
    logic [PL-1:0] pd;
    logic [AW-1:0] ad;
    logic can_load, pop, ph_push, ac_push, ac_drop;
    pd = rnd_phv();
    ad = rnd_act();
    phv_in = pd; phv_in_valid = pv;
    action_in = ad; action_in_valid = av;
    ready_in = rdy;
    can_load = !m_valid || rdy;
    pop      = (phv_q.size() > 0) && (act_q.size() > 0) && can_load;
    ph_push  = pv && (phv_q.size() < DEPTH);
    ac_push  = av && ((act_q.size() < DEPTH) || pop);
    ac_drop  = av && !ac_push;
    @(posedge clk);
    #1;
    if (pop) begin
      m_phv   = phv_q.pop_front();
      m_act   = act_q.pop_front();
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (ph_push) phv_q.push_back(pd);
    if (ac_push) act_q.push_back(ad);
    if (ac_drop) begin
      m_ovf = 1'b1;
      if (m_drop < 16'hFFFF) m_drop++;
    end
    check_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rdy);
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    phv_in_valid = 1'b0;
    action_in_valid = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    phv_in = '0; phv_in_valid = 1'b0;
    action_in = '0; action_in_valid = 1'b0;
    ready_in = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Same-cycle PHV and action: pair visible two edges later, level back to 0.
    cycle(1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);

    // PHVs lead their actions by several cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Back-pressure: fill both FIFOs behind a stalled output, then one ready pulse.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Action overflow: nine actions with no PHVs, then eight PHVs drain them.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Randomised traffic, including simultaneous push/pop on full FIFOs.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0));
    end

    // Reset with PHVs queued and a pair held at the output.
    idle(20, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    idle(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
